// File: rtl/disp_scan6.sv
// -----------------------------------------------------------------------------
// disp_scan6 -- six-digit time-multiplexed 7-segment scanner for ALU operands.
//
// One shared segment bus replaces six dedicated decoders. A prescaler divides
// clk so that each digit slot is held for DIV cycles. Once per full scan
// (on the idx 5 -> 0 step) the operands a, b and s are copied into a snapshot.
// All displayed digits are taken from that snapshot, so one frame never mixes
// two operand sets.
//
// Parameters
//   DIV      : clk cycles per digit slot (>= 2)
//   BLANK_LZ : 1 = blank a tens digit of 0, 0 = show it as "0"
//
// Ports
//   clk   : system clock, all state on rising edge
//   rst   : asynchronous, active-high reset
//   a, b  : ALU operands, unsigned 0..15
//   s     : ALU result, unsigned 0..15
//   seg   : shared segment bus, gfedcba, active-low, registered
//   an    : digit enables, active-low, one-cold, registered
//   frame : one-cycle pulse in the cycle after an operand snapshot
//
// Digit map: idx0 = s units, idx1 = s tens, idx2 = b units, idx3 = b tens,
//            idx4 = a units, idx5 = a tens.
// -----------------------------------------------------------------------------
module disp_scan6 #(
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  // Scan position constants. Reset parks idx on the last slot so that the
  // first tick after release wraps to slot 0 and takes the first snapshot.
  localparam logic [2:0] IDX_FIRST = 3'd0;
  localparam logic [2:0] IDX_LAST  = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [3:0]       snap_a;
  logic [3:0]       snap_b;
  logic [3:0]       snap_s;

  logic       tick;
  logic       wrap;
  logic [2:0] idx_nxt;
  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] src_s;
  logic [3:0] val;
  logic       is_tens;
  logic [3:0] digit;
  logic [6:0] seg_nxt;
  logic [5:0] an_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  assign tick = (cnt == CNT_W'(DIV - 1));
  assign wrap = tick && (idx == IDX_LAST);

  // On the wrap tick the registers being loaded this edge are the live inputs,
  // so slot 0 of the new frame must already see the new snapshot.
  assign src_a = wrap ? a : snap_a;
  assign src_b = wrap ? b : snap_b;
  assign src_s = wrap ? s : snap_s;

  always_comb begin
    idx_nxt = (idx == IDX_LAST) ? IDX_FIRST : idx + 3'd1;

    val     = src_s;
    is_tens = 1'b0;
    case (idx_nxt)
      3'd0:    begin val = src_s; is_tens = 1'b0; end
      3'd1:    begin val = src_s; is_tens = 1'b1; end
      3'd2:    begin val = src_b; is_tens = 1'b0; end
      3'd3:    begin val = src_b; is_tens = 1'b1; end
      3'd4:    begin val = src_a; is_tens = 1'b0; end
      3'd5:    begin val = src_a; is_tens = 1'b1; end
      default: begin val = src_s; is_tens = 1'b0; end
    endcase

    // Operands never exceed 15, so the tens digit is only ever 0 or 1.
    if (is_tens) begin
      digit = (val >= 4'd10) ? 4'd1 : 4'd0;
    end else begin
      digit = (val >= 4'd10) ? (val - 4'd10) : val;
    end

    if (is_tens && (digit == 4'd0)) begin
      seg_nxt = BLANK_LZ ? SEG_BLANK : SEG_ZERO;
    end else begin
      seg_nxt = seg_code(digit);
    end

    an_nxt = ~(6'b000001 << idx_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= IDX_LAST;
      snap_a <= 4'd0;
      snap_b <= 4'd0;
      snap_s <= 4'd0;
      seg    <= SEG_BLANK;
      an     <= 6'b111111;
      frame  <= 1'b0;
    end else begin
      frame <= wrap;
      cnt   <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= idx_nxt;
        seg <= seg_nxt;
        an  <= an_nxt;
      end
      if (wrap) begin
        snap_a <= a;
        snap_b <= b;
        snap_s <= s;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan6.sv
// -----------------------------------------------------------------------------
// tb_disp_scan6 -- self-checking bench for disp_scan6 (DIV = 4).
//
// Two instances share all inputs: one with leading-zero blanking, one without.
// The reference model works in elapsed cycles since reset release: slot number
// = cycles / DIV, the digit shown is derived from the snapshot with plain
// decimal arithmetic (v % 10, v / 10) and a constant segment table.
// -----------------------------------------------------------------------------
module tb_disp_scan6;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [3:0] s = 4'd0;

  logic [6:0] seg1, seg0;
  logic [5:0] an1, an0;
  logic       frame1, frame0;

  disp_scan6 #(.DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s),
    .seg(seg1), .an(an1), .frame(frame1)
  );

  disp_scan6 #(.DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s),
    .seg(seg0), .an(an0), .frame(frame0)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int k = 0;         // rising edges since reset release
  int cur_slot = -1; // digit slot the model expects, -1 before first tick
  int sa = 0, sb = 0, ss = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int slot, input bit blz);
    int v;
    v = (slot < 2) ? ss : (slot < 4) ? sb : sa;
    if (slot % 2 == 0) return seg_tab[v % 10];
    if (v / 10 == 0) return blz ? 7'h7F : 7'h40;
    return seg_tab[v / 10];
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_seg1"}, {1'b0, seg1}, 8'h7F);
    chk({tag, "_an1"}, {2'b0, an1}, 8'h3F);
    chk({tag, "_frame1"}, {7'b0, frame1}, 8'h00);
    chk({tag, "_seg0"}, {1'b0, seg0}, 8'h7F);
    chk({tag, "_an0"}, {2'b0, an0}, 8'h3F);
    chk({tag, "_frame0"}, {7'b0, frame0}, 8'h00);
  endtask

  // Advance one clock and compare both DUTs against the model.
  task automatic step();
    bit         frm;
    logic [5:0] an_exp;
    @(posedge clk);
    #1;
    k++;
    frm = (k >= DIV) && ((k - DIV) % (6 * DIV) == 0);
    if (frm) begin
      sa = a; sb = b; ss = s;
    end
    cur_slot = (k < DIV) ? -1 : ((k / DIV) - 1) % 6;
    chk("frame1", {7'b0, frame1}, {7'b0, frm});
    chk("frame0", {7'b0, frame0}, {7'b0, frm});
    if (cur_slot < 0) begin
      chk("seg1_idle", {1'b0, seg1}, 8'h7F);
      chk("an1_idle", {2'b0, an1}, 8'h3F);
      chk("seg0_idle", {1'b0, seg0}, 8'h7F);
    end else begin
      an_exp = ~(6'd1 << cur_slot);
      chk("an1", {2'b0, an1}, {2'b0, an_exp});
      chk("an0", {2'b0, an0}, {2'b0, an_exp});
      chk("an1_onecold", 8'($countones(an1)), 8'd5);
      chk("seg1", {1'b0, seg1}, {1'b0, exp_seg(cur_slot, 1'b1)});
      chk("seg0", {1'b0, seg0}, {1'b0, exp_seg(cur_slot, 1'b0)});
    end
  endtask

  initial begin
    int guard;
    int v;

    // Reset held over a few edges, then released mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    #2 rst = 1'b0;
    k = 0;

    // All zero operands: blank for DIV cycles, then first frame.
    a = 4'd0; b = 4'd0; s = 4'd0;
    repeat (28) step();

    // a=12, b=7, s=15 over two full frames (both blanking modes).
    a = 4'd12; b = 4'd7; s = 4'd15;
    repeat (48) step();

    // Change s mid-frame at slot 2; the current frame keeps the old snapshot.
    guard = 0;
    while (cur_slot != 2 && guard < 100) begin
      step();
      guard++;
    end
    chk("reach_slot2", 8'(cur_slot), 8'd2);
    s = 4'd3;
    repeat (48) step();

    // Sweep all values on every operand.
    for (int i = 0; i < 16; i++) begin
      v = i;
      a = 4'(v);
      b = 4'(15 - v);
      s = 4'((v + 7) % 16);
      repeat (24) step();
    end

    // Random operands changed at random points, including mid-frame.
    repeat (30) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 30)) step();
    end

    // Asynchronous reset while idx = 3 and cnt = 2.
    guard = 0;
    while (!(cur_slot == 3 && (k % DIV) == 2) && guard < 200) begin
      step();
      guard++;
    end
    chk("reach_idx3_cnt2", 8'(cur_slot * 16 + (k % DIV)), 8'h32);
    #1 rst = 1'b1;
    #1;
    check_reset_vals("rst_async");
    @(posedge clk);
    #1;
    check_reset_vals("rst_edge");
    #2 rst = 1'b0;
    k = 0;
    cur_slot = -1;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    s = 4'($urandom_range(0, 15));
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
